// File: rtl/types_pkg.sv
// Shared types for the pipeline hazard control unit: register/opcode types,
// FSM state encoding and the width of the stall/flush sequence down-counter.
package types_pkg;

  typedef logic [4:0] reg_t;
  typedef logic [6:0] opcode_t;

  localparam opcode_t LOAD   = 7'b0000011;
  localparam opcode_t STORE  = 7'b0100011;
  localparam opcode_t BRANCH = 7'b1100011;
  localparam opcode_t JAL    = 7'b1101111;
  localparam opcode_t JALR   = 7'b1100111;
  localparam opcode_t OP_IMM = 7'b0010011;
  localparam opcode_t HALT_OP = 7'b1111111;

  localparam int SEQ_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LU_STALL = 3'd1,
    REDIRECT = 3'd2,
    MEM_WAIT = 3'd3,
    HALT     = 3'd4
  } hazard_state_t;

endpackage

// File: rtl/hu_perf_counter.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones
// so a long-running measurement never wraps back to a small value.
module hu_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // count register with synchronous clear and saturation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: detects load-use, data-miss, redirect and halt
// hazards and sequences freeze/flush/bubble controls, with perf counters.
module hazard_ctrl_unit
  import types_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_W          = 32
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  reg_t [NUM_SRC-1:0]        rs_de,
  input  logic [NUM_SRC-1:0]        rs_valid_de,
  input  reg_t                      rd_em,
  input  opcode_t                   opcode_em,
  input  logic                      regwrite_em,
  input  logic                      dmem_req,
  input  logic                      dhit,
  input  logic                      branch_em,
  input  logic                      pred_taken_em,
  input  logic                      branch_taken_em,
  input  logic                      jump_em,
  input  logic                      halt_em,
  output logic                      freeze_fd,
  output logic                      freeze_de,
  output logic                      freeze_em,
  output logic                      flush_fd,
  output logic                      flush_de,
  output logic                      bubble_em,
  output logic                      halted,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt,
  output logic [CNT_W-1:0]          miss_cnt
);

  localparam logic [SEQ_CNT_W-1:0] CNT_ZERO  = {SEQ_CNT_W{1'b0}};
  localparam logic [SEQ_CNT_W-1:0] CNT_ONE   = {{(SEQ_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SEQ_CNT_W-1:0] LU_RELOAD = SEQ_CNT_W'(LOAD_USE_STALL - 1);
  localparam logic [SEQ_CNT_W-1:0] FL_RELOAD = SEQ_CNT_W'(FLUSH_CYCLES - 1);

  hazard_state_t          state_r, state_s;
  logic [SEQ_CNT_W-1:0]   cnt_r, cnt_s;
  logic                   src_match_s;
  logic                   lu_hit_s;
  logic                   miss_s;
  logic                   redirect_s;
  logic                   flush_ev_s;

  // any read source operand matching the EX/MEM destination
  always_comb begin
    src_match_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_match_s = src_match_s | (rs_valid_de[i] & (rs_de[i] == rd_em));
    end
  end

  assign lu_hit_s   = (opcode_em == LOAD) && regwrite_em && (rd_em != 5'd0) && src_match_s;
  assign miss_s     = dmem_req && !dhit;
  assign redirect_s = jump_em || (branch_em && (pred_taken_em != branch_taken_em));
  assign halted     = (state_r == HALT);

  // state and sequence-counter register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // next-state and Mealy control outputs; a miss always preempts a sequence
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    freeze_fd  = 1'b0;
    freeze_de  = 1'b0;
    freeze_em  = 1'b0;
    flush_fd   = 1'b0;
    flush_de   = 1'b0;
    bubble_em  = 1'b0;
    flush_ev_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          freeze_fd = 1'b1;
          freeze_de = 1'b1;
          freeze_em = 1'b1;
          state_s   = MEM_WAIT;
        end else if (redirect_s) begin
          flush_fd   = 1'b1;
          flush_de   = 1'b1;
          flush_ev_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_s = REDIRECT;
            cnt_s   = FL_RELOAD;
          end else begin
            state_s = IDLE;
          end
        end else if (lu_hit_s) begin
          freeze_fd = 1'b1;
          freeze_de = 1'b1;
          bubble_em = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            state_s = LU_STALL;
            cnt_s   = LU_RELOAD;
          end else begin
            state_s = IDLE;
          end
        end else if (halt_em) begin
          state_s = HALT;
        end else begin
          state_s = IDLE;
        end
      end
      LU_STALL: begin
        if (miss_s) begin
          freeze_fd = 1'b1;
          freeze_de = 1'b1;
          freeze_em = 1'b1;
          state_s   = MEM_WAIT;
          cnt_s     = CNT_ZERO;
        end else begin
          freeze_fd = 1'b1;
          freeze_de = 1'b1;
          bubble_em = 1'b1;
          if (cnt_r <= CNT_ONE) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
      end
      REDIRECT: begin
        if (miss_s) begin
          freeze_fd = 1'b1;
          freeze_de = 1'b1;
          freeze_em = 1'b1;
          state_s   = MEM_WAIT;
          cnt_s     = CNT_ZERO;
        end else begin
          flush_fd = 1'b1;
          flush_de = 1'b1;
          if (redirect_s) begin
            flush_ev_s = 1'b1;
            cnt_s      = FL_RELOAD;
          end else if (cnt_r <= CNT_ONE) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
      end
      MEM_WAIT: begin
        // the held EX/MEM instruction is re-examined once back in IDLE
        if (miss_s) begin
          freeze_fd = 1'b1;
          freeze_de = 1'b1;
          freeze_em = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      HALT: begin
        freeze_fd = 1'b1;
        freeze_de = 1'b1;
        freeze_em = 1'b1;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  hu_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (bubble_em),
    .count (stall_cnt)
  );

  hu_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (flush_ev_s),
    .count (flush_cnt)
  );

  hu_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (miss_s && (state_r != HALT)),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed scenarios plus random
// traffic, compared each cycle against a remaining-cycles reference model.
module tb_hazard_ctrl_unit;
  import types_pkg::*;

  localparam int NS   = 2;
  localparam int LUS  = 2;
  localparam int FLC  = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  reg_t [NS-1:0] rs_de;
  logic [NS-1:0] rs_valid_de;
  reg_t          rd_em;
  opcode_t       opcode_em;
  logic          regwrite_em, dmem_req, dhit, branch_em, pred_taken_em;
  logic          branch_taken_em, jump_em, halt_em;
  logic          freeze_fd, freeze_de, freeze_em, flush_fd, flush_de, bubble_em, halted;
  logic [CW-1:0] stall_cnt, flush_cnt, miss_cnt;

  hazard_ctrl_unit #(
    .NUM_SRC(NS), .LOAD_USE_STALL(LUS), .FLUSH_CYCLES(FLC), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .rs_de(rs_de), .rs_valid_de(rs_valid_de),
    .rd_em(rd_em), .opcode_em(opcode_em), .regwrite_em(regwrite_em),
    .dmem_req(dmem_req), .dhit(dhit), .branch_em(branch_em),
    .pred_taken_em(pred_taken_em), .branch_taken_em(branch_taken_em),
    .jump_em(jump_em), .halt_em(halt_em),
    .freeze_fd(freeze_fd), .freeze_de(freeze_de), .freeze_em(freeze_em),
    .flush_fd(flush_fd), .flush_de(flush_de), .bubble_em(bubble_em),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic    rst;
    reg_t    rs0, rs1;
    logic [1:0] rv;
    reg_t    rd;
    opcode_t op;
    logic    rw, req, hit, br, pt, bt, jmp, hlt;
  } stim_t;

  typedef struct {
    logic [5:0] ctl;
    logic       hlt;
    int         sc, fc, mc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model: remaining flush/stall cycles, miss-wait flag, halt flag
  bit m_halted, m_wait;
  int m_lu, m_fl, m_sc, m_fc, m_mc;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_wait = 1'b0;
    m_lu = 0; m_fl = 0; m_sc = 0; m_fc = 0; m_mc = 0;
  endtask

  task automatic model(input stim_t s, output exp_t e);
    bit lu, miss, redir, fz3, fz2, fl, bub;
    lu    = (s.op == LOAD) && s.rw && (s.rd != 5'd0) &&
            ((s.rv[0] && s.rs0 == s.rd) || (s.rv[1] && s.rs1 == s.rd));
    miss  = s.req && !s.hit;
    redir = s.jmp || (s.br && (s.pt != s.bt));
    fz3 = 1'b0; fz2 = 1'b0; fl = 1'b0; bub = 1'b0;
    e.hlt = m_halted;
    e.sc = m_sc; e.fc = m_fc; e.mc = m_mc;
    if (miss && !m_halted) m_mc = sat(m_mc);
    if (m_halted) fz3 = 1'b1;
    else if (m_wait) begin
      if (miss) fz3 = 1'b1; else m_wait = 1'b0;
    end else if (miss) begin
      fz3 = 1'b1; m_wait = 1'b1; m_lu = 0; m_fl = 0;
    end else if (m_fl > 0) begin
      if (redir) begin m_fl = FLC; m_fc = sat(m_fc); end
      fl = 1'b1; m_fl--;
    end else if (m_lu > 0) begin
      bub = 1'b1; fz2 = 1'b1; m_lu--;
    end else if (redir) begin
      m_fl = FLC; m_fc = sat(m_fc); fl = 1'b1; m_fl--;
    end else if (lu) begin
      m_lu = LUS; bub = 1'b1; fz2 = 1'b1; m_lu--;
    end else if (s.hlt) m_halted = 1'b1;
    if (bub) m_sc = sat(m_sc);
    e.ctl = {fz2 | fz3, fz2 | fz3, fz3, fl, fl, bub};
    if (!s.rst) model_reset();
  endtask

  function automatic stim_t nop_s();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    s.op  = OP_IMM;
    return s;
  endfunction

  function automatic stim_t rand_s();
    stim_t s;
    int k;
    s = nop_s();
    k = $urandom_range(0, 99);
    s.rs0 = reg_t'($urandom_range(0, 7));
    s.rs1 = reg_t'($urandom_range(0, 7));
    s.rv  = 2'($urandom_range(0, 3));
    s.rd  = reg_t'($urandom_range(0, 7));
    if (k < 35) begin
      s.op = LOAD; s.rw = ($urandom_range(0, 9) != 0);
    end else if (k < 55) begin
      s.op = BRANCH; s.br = 1'b1;
      s.pt = 1'($urandom_range(0, 1)); s.bt = 1'($urandom_range(0, 1));
    end else if (k < 62) begin
      s.op = JAL; s.jmp = 1'b1; s.rw = 1'($urandom_range(0, 1));
    end else if (k < 63) begin
      s.op = HALT_OP; s.hlt = 1'b1;
    end else begin
      s.op = OP_IMM; s.rw = 1'($urandom_range(0, 1));
    end
    s.req = ($urandom_range(0, 3) == 0);
    s.hit = 1'($urandom_range(0, 1));
    s.rst = ($urandom_range(0, 49) != 0);
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST = s.rst; rs_de[0] = s.rs0; rs_de[1] = s.rs1; rs_valid_de = s.rv;
    rd_em = s.rd; opcode_em = s.op; regwrite_em = s.rw; dmem_req = s.req;
    dhit = s.hit; branch_em = s.br; pred_taken_em = s.pt;
    branch_taken_em = s.bt; jump_em = s.jmp; halt_em = s.hlt;
    model(s, e);
    q.push_back(e);
  endtask

  // monitor: pops one expected response per cycle, away from the clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ctl", 32'({freeze_fd, freeze_de, freeze_em, flush_fd, flush_de, bubble_em}), 32'(e.ctl));
        check("halted", 32'(halted), 32'(e.hlt));
        check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        check("flush_cnt", 32'(flush_cnt), 32'(e.fc));
        check("miss_cnt", 32'(miss_cnt), 32'(e.mc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    nRST = 1'b0; rs_de = '0; rs_valid_de = '0; rd_em = '0; opcode_em = OP_IMM;
    regwrite_em = 1'b0; dmem_req = 1'b0; dhit = 1'b0; branch_em = 1'b0;
    pred_taken_em = 1'b0; branch_taken_em = 1'b0; jump_em = 1'b0; halt_em = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    step(nop_s());

    // load-use on rs0 with the other source reading x0
    s = nop_s(); s.op = LOAD; s.rw = 1'b1; s.rd = 5'd5; s.rs0 = 5'd5; s.rv = 2'b01;
    step(s);
    repeat (3) step(nop_s());

    // load to x0 read by a valid x0 source: no hazard
    s = nop_s(); s.op = LOAD; s.rw = 1'b1; s.rd = 5'd0; s.rs0 = 5'd0; s.rv = 2'b01;
    step(s);
    repeat (2) step(nop_s());

    // back-to-back mispredicts: second one reloads the flush sequence
    s = nop_s(); s.op = BRANCH; s.br = 1'b1; s.pt = 1'b0; s.bt = 1'b1;
    step(s);
    step(s);
    repeat (4) step(nop_s());

    // miss arriving during a load-use stall, resolved after four cycles
    s = nop_s(); s.op = LOAD; s.rw = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.rv = 2'b10;
    step(s);
    s = nop_s(); s.req = 1'b1; s.hit = 1'b0;
    repeat (4) step(s);
    s.hit = 1'b1;
    step(s);
    repeat (2) step(nop_s());

    // halt is sticky until reset
    s = nop_s(); s.op = HALT_OP; s.hlt = 1'b1;
    step(s);
    repeat (22) step(nop_s());
    @(negedge CLK);
    check("halt_sticky", 32'(halted), 32'd1);
    s = nop_s(); s.rst = 1'b0;
    step(s);
    repeat (2) step(nop_s());

    // miss counter saturation
    s = nop_s(); s.req = 1'b1; s.hit = 1'b0;
    repeat (20) step(s);
    step(nop_s());
    @(negedge CLK);
    check("miss_sat", 32'(miss_cnt), 32'(CMAX));
    s = nop_s(); s.rst = 1'b0;
    step(s);

    for (int i = 0; i < 1500; i++) step(rand_s());
    step(nop_s());

    repeat (2) @(negedge CLK);
    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the single-cycle hazard unit of the 5-stage RV64 pipeline.
- Detects load-use, data-memory-miss, branch/jump-redirect and halt hazards.
- Drives per-stage freeze/flush/bubble controls, with multi-cycle stall and flush sequencing held in an FSM.
- Exposes saturating performance counters for stall, flush and miss cycles.

Parameters:
- NUM_SRC, 2, number of decode-stage source operands checked (2 or 3, for fused/FMA-style ops).
- LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, cycles flush_fd/flush_de stay high per redirect (1..7); covers a multi-cycle fetch.
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- rs_de  in  NUM_SRC x reg_t  decode/execute source register indices.
- rs_valid_de  in  NUM_SRC  per-source "operand actually read" qualifier.
- rd_em  in  reg_t  destination of the instruction in the EX/MEM latch.
- opcode_em  in  opcode_t  opcode in the EX/MEM latch.
- regwrite_em  in  1  EX/MEM instruction writes rd.
- dmem_req  in  1  MEM stage has a load/store outstanding.
- dhit  in  1  data cache hit/ready.
- branch_em  in  1  EX/MEM holds a conditional branch.
- pred_taken_em  in  1  prediction made for that branch.
- branch_taken_em  in  1  resolved outcome.
- jump_em  in  1  EX/MEM holds JAL/JALR (always redirects).
- halt_em  in  1  EX/MEM holds HALT.
- freeze_fd, freeze_de, freeze_em  out  1 each  hold the respective pipeline latch.
- flush_fd, flush_de  out  1 each  squash the respective latch to NOP.
- bubble_em  out  1  load NOP into EX/MEM.
- halted  out  1  sticky halt indicator.
- stall_cnt, flush_cnt, miss_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (nRST low at a CLK edge): state = IDLE, all counters 0, halted 0. All outputs are 0 in IDLE with no hazard active. A reset mid-stall or mid-flush aborts the sequence on that edge.
- Qualifiers:
  - lu_hit: opcode_em == LOAD && regwrite_em && rd_em != 0 && some i has rs_valid_de[i] && rs_de[i] == rd_em.
  - miss: dmem_req && !dhit.
  - redirect: jump_em || (branch_em && pred_taken_em != branch_taken_em).
- Priority, highest first: halted > miss > redirect > lu_hit. The EX/MEM instruction is either a branch/jump or a load, so redirect and lu_hit are exclusive by construction.
- Outputs are Mealy: the first cycle of any hazard is covered in the detection cycle, with no added latency.
- FSM states: IDLE, LU_STALL, REDIRECT, MEM_WAIT, HALT.
- IDLE:
  - miss -> freeze_fd/de/em=1; go to MEM_WAIT.
  - redirect -> flush_fd=flush_de=1; if FLUSH_CYCLES>1, go to REDIRECT with cnt=FLUSH_CYCLES-1.
  - lu_hit -> freeze_fd=freeze_de=1, bubble_em=1; if LOAD_USE_STALL>1, go to LU_STALL with cnt=LOAD_USE_STALL-1.
  - halt_em -> go to HALT, halted=1 from the next cycle.
- LU_STALL: freeze_fd/de=1, bubble_em=1; decrement cnt; return to IDLE when cnt reaches 1.
- REDIRECT: flush_fd/de=1; decrement cnt; return to IDLE when cnt reaches 1. A second redirect arriving in this state reloads cnt=FLUSH_CYCLES-1.
- MEM_WAIT:
  - All three freezes stay high while miss.
  - On dhit: return to IDLE in the same cycle, with freezes low.
  - A sequence interrupted by the miss is not resumed. The EX/MEM latch was held, so hazards are re-detected in IDLE.
- HALT: freeze_fd/de/em=1 permanently; halted=1; exit only by reset.
- A miss arriving during LU_STALL or REDIRECT preempts the sequence: go to MEM_WAIT, and the remaining cnt is discarded.
- Counters:
  - stall_cnt increments each cycle bubble_em=1.
  - flush_cnt increments once per redirect event (IDLE->REDIRECT, the single-cycle case, or a reload).
  - miss_cnt increments each cycle miss is asserted outside HALT.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Source index x0 never produces a hazard.

Decomposition:
- types_pkg:
  - hazard_state_t enum (IDLE, LU_STALL, REDIRECT, MEM_WAIT, HALT).
  - The existing reg_t and opcode_t, with the LOAD opcode constant.
  - A SEQ_CNT_W localparam (3 bits) for the stall/flush down-counter.
- Sub-module hu_perf_counter: one CNT_W saturating counter with enable, instantiated three times.
- hazard_unit_if is extended with the new signals and an array for rs_de.

Test Plan:
- LW rd_em=5; rs_de={5,0}, rs_valid_de=2'b01; LOAD_USE_STALL=2 -> bubble_em and freeze_fd/de high for exactly 2 cycles; stall_cnt=2.
- LW rd_em=0 with rs_de[0]=0 valid -> no stall, all outputs 0.
- Branch with pred_taken_em=0, branch_taken_em=1; FLUSH_CYCLES=3 -> flush_fd/de high for 3 cycles; flush_cnt=1. A second mispredict in cycle 2 extends the flush to cycle 4; flush_cnt=2.
- dmem_req=1, dhit=0 for 4 cycles during a LU_STALL -> all freezes high for 4 cycles; miss_cnt=4; bubble drops. On dhit, return to IDLE with no residual stall.
- halt_em=1 -> halted=1 the next cycle; freezes stuck high for 20+ cycles; nRST low for 1 edge clears everything.
- CNT_W=4; force 20 miss cycles -> miss_cnt saturates at 15.
